// File: rtl/rocc_unit_pkg.sv
// Shared types for the RoCC execute-stage unit: issue operands, write-back
// exception, and the accelerator command/response records.
package rocc_unit_pkg;

  localparam int TRANS_ID_BITS        = 3;
  localparam int ROCC_TIMEOUT_DEFAULT = 1024;

  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

  typedef struct packed {
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    RESP  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } rocc_state_e;

  typedef struct packed {
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } rocc_cmd_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } rocc_resp_t;

endpackage

// File: rtl/rocc_unit.sv
// Single-outstanding RoCC functional unit: forwards one command to an external
// accelerator, collects the response (or times out) and writes back once.
module rocc_unit
  import rocc_unit_pkg::*;
#(
  parameter int TIMEOUT = ROCC_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fu_data_t                 fu_data_i,
  input  logic                     rocc_valid_i,
  input  logic [6:0]               rocc_funct7_i,
  input  logic [4:0]               rocc_rd_i,
  output logic                     rocc_ready_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [6:0]               cmd_funct7_o,
  output logic [4:0]               cmd_rd_o,
  output logic [63:0]              cmd_rs1_o,
  output logic [63:0]              cmd_rs2_o,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [63:0]              resp_data_i,
  output logic [63:0]              rocc_result_o,
  output logic [TRANS_ID_BITS-1:0] rocc_trans_id_o,
  output logic                     rocc_wb_valid_o,
  output exception_t               rocc_exception_o
);

  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  rocc_state_e              state_r, state_s;
  rocc_cmd_t                cmd_r, cmd_s;
  logic [TRANS_ID_BITS-1:0] trans_id_r, trans_id_s;
  logic [63:0]              result_r, result_s;
  exception_t               exc_r, exc_s;
  logic [CNT_W-1:0]         cnt_r, cnt_s;

  // Next-state, datapath latching and timeout counting.
  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    trans_id_s = trans_id_r;
    result_s   = result_r;
    exc_s      = exc_r;
    cnt_s      = cnt_r;
    case (state_r)
      IDLE: begin
        if (rocc_valid_i && !flush_i) begin
          cmd_s.funct7 = rocc_funct7_i;
          cmd_s.rd     = rocc_rd_i;
          cmd_s.rs1    = fu_data_i.operand_a;
          cmd_s.rs2    = fu_data_i.operand_b;
          trans_id_s   = fu_data_i.trans_id;
          result_s     = 64'd0;
          exc_s        = '0;
          cnt_s        = '0;
          state_s      = CMD;
        end else begin
          state_s = IDLE;
        end
      end
      CMD: begin
        if (cmd_ready_i) begin
          cnt_s = '0;
          // A flushed-but-sent command still owes us a response when rd!=0.
          if (flush_i) begin
            state_s = (cmd_r.rd != 5'd0) ? DRAIN : IDLE;
          end else if (cmd_r.rd != 5'd0) begin
            state_s = RESP;
          end else begin
            result_s = 64'd0;
            state_s  = WB;
          end
        end else if (flush_i) begin
          state_s = IDLE;
        end else begin
          state_s = CMD;
        end
      end
      RESP: begin
        if (flush_i) begin
          state_s = resp_valid_i ? IDLE : DRAIN;
        end else if (resp_valid_i) begin
          result_s = resp_data_i;
          exc_s    = '0;
          state_s  = WB;
        end else if (TMO_EN && (cnt_r == TMO_LAST)) begin
          result_s    = 64'd0;
          exc_s.valid = 1'b1;
          exc_s.cause = ILLEGAL_INSTR;
          exc_s.tval  = 64'd0;
          state_s     = WB;
        end else begin
          if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_s = cnt_r;
          end
          state_s = RESP;
        end
      end
      WB: begin
        state_s = IDLE;
      end
      DRAIN: begin
        if (resp_valid_i) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      cmd_r      <= '0;
      trans_id_r <= '0;
      result_r   <= 64'd0;
      exc_r      <= '0;
      cnt_r      <= '0;
    end else begin
      state_r    <= state_s;
      cmd_r      <= cmd_s;
      trans_id_r <= trans_id_s;
      result_r   <= result_s;
      exc_r      <= exc_s;
      cnt_r      <= cnt_s;
    end
  end

  // Handshake strobes decode straight from the state register.
  assign rocc_ready_o    = (state_r == IDLE);
  assign cmd_valid_o     = (state_r == CMD);
  assign resp_ready_o    = (state_r == RESP) || (state_r == DRAIN);
  assign rocc_wb_valid_o = (state_r == WB) && !flush_i;

  assign cmd_funct7_o     = cmd_r.funct7;
  assign cmd_rd_o         = cmd_r.rd;
  assign cmd_rs1_o        = cmd_r.rs1;
  assign cmd_rs2_o        = cmd_r.rs2;
  assign rocc_result_o    = result_r;
  assign rocc_trans_id_o  = trans_id_r;
  assign rocc_exception_o = rocc_wb_valid_o ? exc_r : '0;

endmodule

// File: doc/rocc_unit.md
Name: rocc_unit

Overview:
- Execute-stage functional unit that consumes RoCC-class instructions dispatched by the issue stage (rocc_valid/rocc_funct7/rocc_rd with fu_data operands).
- Forwards one custom command at a time to an external accelerator over a valid/ready command channel and collects its response.
- Returns the result, or a timeout exception, on a scoreboard write-back port tagged with the instruction's trans_id.
- Single outstanding instruction; its ready output gates issue.

Parameters:
- TIMEOUT, 1024: maximum cycles spent in RESP before a timeout exception is raised; 0 disables the timeout.
- CNT_W, 16: width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  kill in-flight instruction (mispredict/exception)
- fu_data_i  in  fu_data_t  operand_a=rs1, operand_b=rs2, trans_id
- rocc_valid_i  in  1  issue stage dispatches a RoCC instruction
- rocc_funct7_i  in  7  instruction funct7
- rocc_rd_i  in  5  destination register; 0 means no response expected
- rocc_ready_o  out  1  unit can accept a new instruction
- cmd_valid_o  out  1  command valid to accelerator
- cmd_ready_i  in  1  accelerator accepts command
- cmd_funct7_o  out  7  latched funct7
- cmd_rd_o  out  5  latched rd
- cmd_rs1_o  out  64  latched operand_a
- cmd_rs2_o  out  64  latched operand_b
- resp_valid_i  in  1  accelerator response valid
- resp_ready_o  out  1  unit accepts response
- resp_data_i  in  64  response data
- rocc_result_o  out  64  write-back data
- rocc_trans_id_o  out  TRANS_ID_BITS  write-back tag
- rocc_wb_valid_o  out  1  write-back strobe (wt_valid)
- rocc_exception_o  out  exception_t  write-back exception

Behaviour:
- Interface: one clock, clk_i; reset is synchronous and active-low, rst_ni. All state updates on the rising edge of clk_i.
- Reset (rst_ni=0 at an edge): state=IDLE; rocc_ready_o=1; cmd_valid_o=0; resp_ready_o=0; rocc_wb_valid_o=0; rocc_result_o=0; rocc_trans_id_o=0; rocc_exception_o all fields 0; timeout counter=0; command registers=0. Reset mid-operation abandons the command; no write-back is produced.
- States: IDLE, CMD, RESP, WB, DRAIN.
- IDLE:
  - rocc_ready_o=1.
  - rocc_valid_i && !flush_i latches funct7, rd, operand_a/b and trans_id, then moves to CMD.
  - rocc_valid_i together with flush_i is ignored.
- CMD:
  - cmd_valid_o=1, driven from registers; the first assertion is 1 cycle after acceptance.
  - Outputs stay stable until cmd_ready_i.
  - cmd_ready_i with rd!=0: go to RESP and clear the counter.
  - cmd_ready_i with rd==0: go to WB with result 0.
  - flush_i without cmd_ready_i: go to IDLE; the command is never sent.
  - flush_i together with cmd_ready_i: the command is sent; with rd!=0 go to DRAIN, with rd==0 go to IDLE.
- RESP:
  - resp_ready_o=1; the counter increments each cycle.
  - resp_valid_i: latch resp_data_i into the result, go to WB.
  - TIMEOUT!=0 and counter==TIMEOUT-1 without a response: go to WB with exception.valid=1, cause=riscv::ILLEGAL_INSTR, tval=0, result=0.
  - flush_i: go to DRAIN, or to IDLE if resp_valid_i is high the same cycle.
  - A response arriving in the same cycle as the timeout wins; no exception is raised.
- WB:
  - rocc_wb_valid_o=1 for exactly one cycle with the registered result, trans_id and exception, then IDLE.
  - rocc_ready_o=0 during WB.
  - flush_i in WB suppresses rocc_wb_valid_o.
- DRAIN:
  - resp_ready_o=1; the response is consumed and discarded, then IDLE.
  - No timeout applies; flush_i is ignored.
- rocc_exception_o.valid=0 whenever rocc_wb_valid_o=0.
- Best-case latency, accept to write-back, with rd!=0: 1 (CMD) + 1 (RESP, response accepted) + 1 (WB) = write-back visible 3 cycles after the accept edge.
- Throughput: one instruction per ≥3 cycles.
- Counter is CNT_W bits and saturates; it cannot wrap because the timeout fires first.

Decomposition:
- ariane_pkg gains:
  - rocc_state_e enum: IDLE, CMD, RESP, WB, DRAIN.
  - rocc_cmd_t struct: funct7, rd, rs1, rs2.
  - rocc_resp_t struct: rd, data.
  - Constant ROCC_TIMEOUT_DEFAULT=1024.
- fu_data_t, exception_t and TRANS_ID_BITS are reused unchanged.
- No sub-module is required; the timeout counter stays inline.

Test Plan:
- Basic op: dispatch funct7=7'h01, rd=5, rs1=0x10, rs2=0x20, trans_id=3; cmd_ready_i=1; resp_data_i=0x30 the next cycle -> cmd fields match; rocc_wb_valid_o pulses once with result 0x30, trans_id 3, exception.valid=0, 3 cycles after accept.
- No-response op: rd=0, cmd_ready_i held 0 for 4 cycles then 1 -> cmd outputs stable throughout; write-back with result 0 and no resp_ready_o assertion.
- Timeout: TIMEOUT=8, resp_valid_i never asserted -> after 8 RESP cycles, write-back with exception.valid=1, cause=ILLEGAL_INSTR, result 0; rocc_ready_o returns to 1 the next cycle.
- Flush in CMD: flush_i while cmd_ready_i=0 -> cmd_valid_o drops the next cycle, no write-back, rocc_ready_o=1.
- Flush in RESP: flush_i, then response 5 cycles later -> DRAIN consumes it, rocc_wb_valid_o stays 0, and the next instruction completes normally.
- Synchronous reset mid-RESP: rst_ni=0 for one edge -> all outputs at reset values the next cycle; a subsequent late resp_valid_i is ignored (resp_ready_o=0).
